// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC select encoding for the program-counter generator.
package pc_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          INC_DEF       = 4;
    localparam int          RAS_DEPTH_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0080;

    typedef enum logic [2:0] {
        TRAP,
        REDIR,
        RET,
        PEND,
        SEQ
    } npc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored, and push+pop together replaces the top entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            clrPC_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_addr_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   top_ptr_q, top_ptr_d, wr_ptr;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        wr_ptr    = top_ptr_q;
        wr_en     = 1'b0;
        if (push_i && pop_i) begin
            wr_en = 1'b1;
            if (count_q == '0) count_d = CW'(1);
        end else if (push_i) begin
            top_ptr_d = top_ptr_q + PW'(1);
            wr_ptr    = top_ptr_d;
            wr_en     = 1'b1;
            if (count_q != CW'(RAS_DEPTH)) count_d = count_q + CW'(1);
        end else if (pop_i && count_q != '0) begin
            top_ptr_d = top_ptr_q - PW'(1);
            count_d   = count_q - CW'(1);
        end
    end

    // NOTE: entry storage has no reset; only pointer and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= push_addr_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clrPC_n) begin
        if (!clrPC_n) begin
            top_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
        end
    end

    assign top_o   = mem_q[top_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(RAS_DEPTH));

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised next-PC mux, a pending-redirect register for
// redirects that arrive during a stall, and the PC register itself.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              INC       = INC_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF),
    parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            clrPC_n,
    input  logic            pc_enable,
    input  logic            fetch_ready,
    input  logic            branch,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic            trap,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect_pend,
    output logic            ras_empty,
    output logic            ras_full
);

    logic [XLEN-1:0] pc_q, pend_addr_q, npc, seq_pc, ras_top;
    logic            pc_valid_q, pend_q;
    logic            advance, live_redir, ras_push, ras_pop;
    npc_sel_e        sel;

    // The first edge after reset release only raises pc_valid; it never advances.
    assign advance    = pc_enable && fetch_ready && pc_valid_q;
    assign live_redir = trap || branch || jump || ret;
    assign seq_pc     = pc_q + XLEN'(INC);
    assign ras_push   = jump && call && !trap;
    assign ras_pop    = ret && !trap;

    always_comb begin
        sel = SEQ;
        if (trap)                 sel = TRAP;
        else if (branch || jump)  sel = REDIR;
        else if (ret)             sel = RET;
        else if (pend_q)          sel = PEND;

        case (sel)
            TRAP:    npc = TRAP_VEC;
            REDIR:   npc = target;
            RET:     npc = ras_empty ? target : ras_top;
            PEND:    npc = pend_addr_q;
            default: npc = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge clrPC_n) begin
        if (!clrPC_n) begin
            pc_q        <= RESET_PC;
            pc_valid_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pc_valid_q <= 1'b1;
            if (advance) begin
                pc_q   <= npc;
                pend_q <= 1'b0;
            end else if (live_redir) begin
                pend_q      <= 1'b1;
                pend_addr_q <= npc;
            end
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .clrPC_n     (clrPC_n),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_addr_i (seq_pc),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    assign pc            = pc_q;
    assign pc_valid      = pc_valid_q;
    assign redirect_pend = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential fetch, stalled redirects, return stack,
// trap priority, asynchronous reset and address wrap.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        clrPC_n, pc_enable, fetch_ready;
    logic        branch, jump, call, ret, trap;
    logic [31:0] target;
    logic [31:0] pc;
    logic        pc_valid, redirect_pend, ras_empty, ras_full;

    int n_cmp = 0;
    int n_bad = 0;

    pc_gen dut (
        .clk           (clk),
        .clrPC_n       (clrPC_n),
        .pc_enable     (pc_enable),
        .fetch_ready   (fetch_ready),
        .branch        (branch),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .trap          (trap),
        .target        (target),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .redirect_pend (redirect_pend),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic fr, input logic br, input logic jp,
                         input logic cl, input logic rt, input logic tp, input logic [31:0] tgt);
        pc_enable = en; fetch_ready = fr; branch = br; jump = jp;
        call = cl; ret = rt; trap = tp; target = tgt;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h4, 32'h8, 32'hC};
        clrPC_n = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
        #12;
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", pc_valid); end
        n_cmp++; if (redirect_pend !== 1'b0) begin n_bad++; $display("FAIL rst_pend: got %b want 0", redirect_pend); end
        n_cmp++; if ({ras_empty, ras_full} !== 2'b10) begin n_bad++; $display("FAIL rst_ras: got %b want 10", {ras_empty, ras_full}); end
        clrPC_n = 1'b1;
        cyc();
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL first_edge_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (pc_valid !== 1'b1) begin n_bad++; $display("FAIL first_edge_valid: got %b want 1", pc_valid); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (pc !== exp_seq[i]) begin n_bad++; $display("FAIL seq_%0d: got %h want %h", i, pc, exp_seq[i]); end
        end
    endtask

    task automatic test_stall_branch();
        drive(0, 1, 1, 0, 0, 0, 0, 32'h100);
        cyc();
        n_cmp++; if (redirect_pend !== 1'b1) begin n_bad++; $display("FAIL stall1_pend: got %b want 1", redirect_pend); end
        n_cmp++; if (pc !== 32'hC) begin n_bad++; $display("FAIL stall1_pc: got %h want %h", pc, 32'hC); end
        drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'hC || redirect_pend !== 1'b1) begin n_bad++; $display("FAIL stall2: got pc=%h pend=%b want pc=%h pend=1", pc, redirect_pend, 32'hC); end
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h100 || redirect_pend !== 1'b0) begin n_bad++; $display("FAIL pend_apply: got pc=%h pend=%b want pc=%h pend=0", pc, redirect_pend, 32'h100); end
        cyc();
        n_cmp++; if (pc !== 32'h104) begin n_bad++; $display("FAIL after_pend: got %h want %h", pc, 32'h104); end
        drive(1, 0, 0, 1, 0, 0, 0, 32'h40);
        cyc();
        n_cmp++; if (pc !== 32'h104 || redirect_pend !== 1'b1) begin n_bad++; $display("FAIL not_ready: got pc=%h pend=%b want pc=%h pend=1", pc, redirect_pend, 32'h104); end
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h40) begin n_bad++; $display("FAIL ready_apply: got %h want %h", pc, 32'h40); end
    endtask

    task automatic test_call_ret();
        drive(1, 1, 0, 1, 1, 0, 0, 32'h200);
        cyc();
        n_cmp++; if (pc !== 32'h200 || ras_empty !== 1'b0) begin n_bad++; $display("FAIL call: got pc=%h empty=%b want pc=%h empty=0", pc, ras_empty, 32'h200); end
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
        cyc();
        drive(1, 1, 0, 0, 0, 1, 0, 32'h999);
        cyc();
        n_cmp++; if (pc !== 32'h44) begin n_bad++; $display("FAIL ret_pc: got %h want %h", pc, 32'h44); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [5];
        exp_ret = '{32'h4004, 32'h3004, 32'h2004, 32'h1004, 32'h7770};
        for (int i = 1; i <= 5; i++) begin
            drive(1, 1, 0, 1, 1, 0, 0, 32'(i) << 12);
            cyc();
        end
        n_cmp++; if (pc !== 32'h5000) begin n_bad++; $display("FAIL call5_pc: got %h want %h", pc, 32'h5000); end
        n_cmp++; if (ras_full !== 1'b1) begin n_bad++; $display("FAIL ras_full: got %b want 1", ras_full); end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0, 1, 0, 32'h7770);
            cyc();
            n_cmp++; if (pc !== exp_ret[i]) begin n_bad++; $display("FAIL ret_%0d: got %h want %h", i, pc, exp_ret[i]); end
            if (i == 0) begin
                n_cmp++; if (ras_full !== 1'b0) begin n_bad++; $display("FAIL full_after_pop: got %b want 0", ras_full); end
            end
            if (i == 3) begin
                n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL empty_after_4: got %b want 1", ras_empty); end
            end
        end
    endtask

    task automatic test_call_ret_same();
        drive(1, 1, 0, 1, 1, 0, 0, 32'h8000);
        cyc();
        drive(1, 1, 0, 1, 1, 1, 0, 32'h9000);
        cyc();
        n_cmp++; if (pc !== 32'h9000 || {ras_empty, ras_full} !== 2'b00) begin n_bad++; $display("FAIL swap: got pc=%h ef=%b want pc=%h ef=00", pc, {ras_empty, ras_full}, 32'h9000); end
        drive(1, 1, 0, 0, 0, 1, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h8004 || ras_empty !== 1'b1) begin n_bad++; $display("FAIL swap_ret: got pc=%h empty=%b want pc=%h empty=1", pc, ras_empty, 32'h8004); end
        drive(1, 1, 0, 1, 1, 1, 0, 32'hA000);
        cyc();
        n_cmp++; if (pc !== 32'hA000 || ras_empty !== 1'b0) begin n_bad++; $display("FAIL swap_empty: got pc=%h empty=%b want pc=%h empty=0", pc, ras_empty, 32'hA000); end
        drive(1, 1, 0, 0, 0, 1, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h8008 || ras_empty !== 1'b1) begin n_bad++; $display("FAIL swap_empty_ret: got pc=%h empty=%b want pc=%h empty=1", pc, ras_empty, 32'h8008); end
    endtask

    task automatic test_trap();
        drive(1, 1, 0, 1, 1, 0, 0, 32'hB000);
        cyc();
        drive(1, 1, 1, 1, 1, 1, 1, 32'hC000);
        cyc();
        n_cmp++; if (pc !== 32'h80) begin n_bad++; $display("FAIL trap_pc: got %h want %h", pc, 32'h80); end
        n_cmp++; if ({ras_empty, ras_full} !== 2'b00) begin n_bad++; $display("FAIL trap_ras: got %b want 00", {ras_empty, ras_full}); end
        drive(1, 1, 0, 0, 0, 1, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h800C || ras_empty !== 1'b1) begin n_bad++; $display("FAIL trap_stack_kept: got pc=%h empty=%b want pc=%h empty=1", pc, ras_empty, 32'h800C); end
        drive(0, 1, 0, 0, 0, 0, 1, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h800C || redirect_pend !== 1'b1) begin n_bad++; $display("FAIL trap_latch: got pc=%h pend=%b want pc=%h pend=1", pc, redirect_pend, 32'h800C); end
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h80) begin n_bad++; $display("FAIL trap_pend_apply: got %h want %h", pc, 32'h80); end
        cyc();
        n_cmp++; if (pc !== 32'h84) begin n_bad++; $display("FAIL trap_seq: got %h want %h", pc, 32'h84); end
    endtask

    task automatic test_reset_mid_stall();
        drive(0, 1, 0, 1, 1, 0, 0, 32'h300);
        cyc();
        n_cmp++; if (redirect_pend !== 1'b1 || ras_empty !== 1'b0) begin n_bad++; $display("FAIL pre_rst: got pend=%b empty=%b want pend=1 empty=0", redirect_pend, ras_empty); end
        #2 clrPC_n = 1'b0;
        #1;
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL async_rst_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if ({pc_valid, redirect_pend, ras_empty, ras_full} !== 4'b0010) begin n_bad++; $display("FAIL async_rst_flags: got %b want 0010", {pc_valid, redirect_pend, ras_empty, ras_full}); end
        #2 clrPC_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h0 || pc_valid !== 1'b1 || redirect_pend !== 1'b0) begin n_bad++; $display("FAIL rel_edge: got pc=%h v=%b p=%b want pc=0 v=1 p=0", pc, pc_valid, redirect_pend); end
    endtask

    task automatic test_wrap();
        drive(1, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        cyc();
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_setup: got %h want %h", pc, 32'hFFFF_FFFC); end
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
        cyc();
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL wrap: got %h want %h", pc, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_stall_branch();
        test_call_ret();
        test_ras_overflow();
        test_call_ret_same();
        test_trap();
        test_reset_mid_stall();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
